uart_tx_sched: RTL and testbench

Scheduler that shares the single uart_tx byte channel between two requesters. The first is a periodic ADC telemetry frame built from volt_ch1/volt_ch2. The second is an echo path that returns bytes received from uart_rx. It sits in fpga_slave between ad9238, uart_rx and uart_tx. Frames are never interleaved with echo bytes; echo bytes go out only between frames.

---
 rtl/uart_tx_sched.sv | 213 +++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Shares the single uart_tx byte channel between a periodic ADC telemetry
// frame and an rx echo path. Frames are never interleaved with echo bytes;
// echo bytes are granted one at a time, only between frames.
//
// Ports:
//   sys_clk, sys_rst_n       clock, asynchronous active-low reset
//   enable                   1 = periodic telemetry ticks enabled
//   volt_ch1, volt_ch2       ADC channel values in mV (sys_clk domain)
//   rx_data/_valid/_ready    byte stream from uart_rx into the echo FIFO
//   tx_data/_valid/_ready    byte stream to uart_tx (registered outputs)
//   frame_seq                sequence number of the next frame
//   echo_ovf                 sticky: rx byte offered while FIFO full
//   frame_miss               sticky: tick while a frame was already pending
module uart_tx_sched #(
    parameter int PERIOD_CYCLES = 100000000,
    parameter int ECHO_DEPTH    = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic [15:0] volt_ch1,
    input  logic [15:0] volt_ch2,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    output logic        rx_data_ready,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    output logic [7:0]  frame_seq,
    output logic        echo_ovf,
    output logic        frame_miss
);

    localparam int CW = $clog2(PERIOD_CYCLES);
    localparam int AW = $clog2(ECHO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD_CYCLES - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(ECHO_DEPTH);

    typedef enum logic [1:0] {IDLE, FRAME, ECHO} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic          frame_pend;
    logic [AW:0]   fifo_cnt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    fifo_mem [ECHO_DEPTH];
    logic          fifo_empty, push, pop, xfer;
    logic [2:0]    byte_idx, byte_idx_nxt, next_idx;
    logic [7:0]    tx_data_nxt, next_byte;
    logic          tx_valid_nxt;
    logic [7:0]    snap_seq;
    logic [15:0]   snap_ch1, snap_ch2;
    logic [7:0]    csum;
    logic          start_frame, end_frame;

    assign tick          = enable && (tick_cnt == CNT_LAST);
    assign xfer          = tx_data_valid && tx_data_ready;
    assign start_frame   = (state == IDLE) && frame_pend;
    assign end_frame     = (state == FRAME) && xfer && (byte_idx == 3'd7);
    assign rx_data_ready = (fifo_cnt != FIFO_FULL);
    assign fifo_empty    = (fifo_cnt == '0);
    assign push          = rx_data_valid && rx_data_ready;
    assign pop           = (state == ECHO) && xfer;
    assign csum          = snap_seq + snap_ch1[15:8] + snap_ch1[7:0]
                         + snap_ch2[15:8] + snap_ch2[7:0];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            tick_cnt <= '0;
        else if (!enable || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CW'(1);
    end

    // A tick arriving in the very cycle the pending frame is taken queues a
    // fresh frame rather than counting as a miss.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_pend <= 1'b0;
            frame_miss <= 1'b0;
        end else if (tick) begin
            frame_pend <= 1'b1;
            if (frame_pend && !start_frame)
                frame_miss <= 1'b1;
        end else if (start_frame) begin
            frame_pend <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            snap_seq  <= '0;
            snap_ch1  <= '0;
            snap_ch2  <= '0;
            frame_seq <= '0;
        end else begin
            if (start_frame) begin
                snap_seq <= frame_seq;
                snap_ch1 <= volt_ch1;
                snap_ch2 <= volt_ch2;
            end
            if (end_frame)
                frame_seq <= frame_seq + 8'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push)
            fifo_mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            echo_ovf <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (rx_data_valid && !rx_data_ready)
                echo_ovf <= 1'b1;
        end
    end

    // State register; tx_data/tx_data_valid/byte_idx are registered alongside
    // it so the outputs change on the same edge as the state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            byte_idx      <= '0;
        end else begin
            state         <= state_nxt;
            tx_data       <= tx_data_nxt;
            tx_data_valid <= tx_valid_nxt;
            byte_idx      <= byte_idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (frame_pend)
                    state_nxt = FRAME;
                else if (!fifo_empty)
                    state_nxt = ECHO;
            end
            FRAME: if (xfer && byte_idx == 3'd7) state_nxt = IDLE;
            ECHO:  if (xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Byte that follows the current one in the frame, from the snapshot.
    always_comb begin
        next_idx = byte_idx + 3'd1;
        case (next_idx)
            3'd0:    next_byte = 8'hA5;
            3'd1:    next_byte = 8'h5A;
            3'd2:    next_byte = snap_seq;
            3'd3:    next_byte = snap_ch1[15:8];
            3'd4:    next_byte = snap_ch1[7:0];
            3'd5:    next_byte = snap_ch2[15:8];
            3'd6:    next_byte = snap_ch2[7:0];
            default: next_byte = csum;
        endcase
    end

    // Next-cycle output values; tx_data only moves on entry or after a transfer.
    always_comb begin
        tx_valid_nxt = tx_data_valid;
        tx_data_nxt  = tx_data;
        byte_idx_nxt = byte_idx;
        case (state)
            IDLE: begin
                if (frame_pend) begin
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = 8'hA5;
                    byte_idx_nxt = 3'd0;
                end else if (!fifo_empty) begin
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = fifo_mem[rd_ptr];
                end
            end
            FRAME: begin
                if (xfer) begin
                    if (byte_idx == 3'd7) begin
                        tx_valid_nxt = 1'b0;
                    end else begin
                        byte_idx_nxt = next_idx;
                        tx_data_nxt  = next_byte;
                    end
                end
            end
            ECHO: if (xfer) tx_valid_nxt = 1'b0;
            default: tx_valid_nxt = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched (PERIOD_CYCLES=100, ECHO_DEPTH=4).
// Directed phases with randomized data; expected byte streams and timing
// are computed from the frame format and tick period arithmetic.
module tb_uart_tx_sched;

    localparam int PERIOD = 100;
    localparam int DEPTH  = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        enable;
    logic [15:0] volt_ch1, volt_ch2;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        rx_data_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic [7:0]  frame_seq;
    logic        echo_ovf;
    logic        frame_miss;

    uart_tx_sched #(.PERIOD_CYCLES(PERIOD), .ECHO_DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
        .volt_ch1(volt_ch1), .volt_ch2(volt_ch2),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .frame_seq(frame_seq), .echo_ovf(echo_ovf), .frame_miss(frame_miss)
    );

    always #5 sys_clk = ~sys_clk;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int cyc        = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         rise_q[$];
    int         xfer_cyc_q[$];

    logic       hold_pend  = 1'b0;
    logic [7:0] hold_data  = 8'h00;
    logic       prev_valid = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Monitor: samples mid-cycle, so values seen here are what the next edge
    // will act on. Logs transfers, valid rises, and checks hold-until-accept.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            hold_pend  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (hold_pend) begin
                checkOutput("hold_valid", {31'd0, tx_data_valid}, 32'd1);
                checkOutput("hold_data", {24'd0, tx_data}, {24'd0, hold_data});
            end
            if (tx_data_valid && !prev_valid)
                rise_q.push_back(cyc);
            if (tx_data_valid && tx_data_ready) begin
                got_q.push_back(tx_data);
                xfer_cyc_q.push_back(cyc);
            end
            hold_pend  = tx_data_valid && !tx_data_ready;
            hold_data  = tx_data;
            prev_valid = tx_data_valid;
        end
    end

    task automatic applyStimulus(input logic en, input logic rdy, input logic rxv,
                                 input logic [7:0] rxd);
        enable        = en;
        tx_data_ready = rdy;
        rx_data_valid = rxv;
        rx_data       = rxd;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    task automatic waitTransfers(input int n, input int budget, input string tag);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            waitCycles(1);
            k++;
        end
        checkOutput({tag, "_transfers_reached"}, {31'd0, got_q.size() >= n}, 32'd1);
    endtask

    task automatic clearLogs();
        got_q.delete();
        exp_q.delete();
        rise_q.delete();
        xfer_cyc_q.delete();
    endtask

    // Reference frame: header, seq, big-endian channels, byte-sum checksum.
    task automatic expectFrame(input int seq, input int ch1, input int ch2);
        int sum;
        sum = (seq + ch1 / 256 + ch1 % 256 + ch2 / 256 + ch2 % 256) % 256;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(seq));
        exp_q.push_back(8'(ch1 / 256));
        exp_q.push_back(8'(ch1 % 256));
        exp_q.push_back(8'(ch2 / 256));
        exp_q.push_back(8'(ch2 % 256));
        exp_q.push_back(8'(sum));
    endtask

    task automatic checkStream(input string tag);
        checkOutput({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0;
        int ch1, ch2;
        int k;
        logic started;
        logic [7:0] b [5];
        logic [7:0] e;

        sys_rst_n = 1'b0;
        volt_ch1  = 16'h0000;
        volt_ch2  = 16'h0000;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset values
        waitCycles(3);
        checkOutput("rst_tx_data", {24'd0, tx_data}, 32'h0);
        checkOutput("rst_tx_valid", {31'd0, tx_data_valid}, 32'd0);
        checkOutput("rst_frame_seq", {24'd0, frame_seq}, 32'd0);
        checkOutput("rst_echo_ovf", {31'd0, echo_ovf}, 32'd0);
        checkOutput("rst_frame_miss", {31'd0, frame_miss}, 32'd0);
        sys_rst_n = 1'b1;
        #1;
        checkOutput("rst_rx_ready", {31'd0, rx_data_ready}, 32'd1);
        waitCycles(2);

        // Two periodic frames with fixed channel values
        $display("[TB] phase: periodic frames");
        clearLogs();
        volt_ch1 = 16'h0CE4;
        volt_ch2 = 16'h0001;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        c0 = cyc;
        waitTransfers(16, 300, "b");
        enable = 1'b0;
        expectFrame(0, 16'h0CE4, 16'h0001);
        expectFrame(1, 16'h0CE4, 16'h0001);
        checkStream("b");
        if (rise_q.size() >= 2) begin
            checkOutput("b_first_rise_cycle", rise_q[0], c0 + PERIOD + 1);
            checkOutput("b_second_rise_cycle", rise_q[1], c0 + 2 * PERIOD + 1);
        end
        if (xfer_cyc_q.size() >= 16) begin
            checkOutput("b_frame0_span", xfer_cyc_q[7] - xfer_cyc_q[0], 32'd7);
            checkOutput("b_frame1_span", xfer_cyc_q[15] - xfer_cyc_q[8], 32'd7);
        end
        checkOutput("b_frame_seq", {24'd0, frame_seq}, 32'd2);
        checkOutput("b_frame_miss", {31'd0, frame_miss}, 32'd0);

        // Frame with random ready and channels changing after snapshot
        $display("[TB] phase: random ready");
        clearLogs();
        ch1 = int'($urandom_range(0, 65535));
        ch2 = int'($urandom_range(0, 65535));
        volt_ch1 = 16'(ch1);
        volt_ch2 = 16'(ch2);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        c0 = cyc;
        started = 1'b0;
        k = 0;
        while (got_q.size() < 8 && k < 400) begin
            if (tx_data_valid)
                started = 1'b1;
            tx_data_ready = (cyc > c0 + 150) ? 1'b1 : 1'($urandom_range(0, 1));
            if (started) begin
                volt_ch1 = 16'($urandom_range(0, 65535));
                volt_ch2 = 16'($urandom_range(0, 65535));
            end
            waitCycles(1);
            k++;
        end
        enable = 1'b0;
        tx_data_ready = 1'b1;
        checkOutput("c_transfers_reached", {31'd0, got_q.size() >= 8}, 32'd1);
        waitCycles(5);
        expectFrame(2, ch1, ch2);
        checkStream("c");
        checkOutput("c_frame_seq", {24'd0, frame_seq}, 32'd3);
        checkOutput("c_idle_valid", {31'd0, tx_data_valid}, 32'd0);

        // Plain echo of three bytes
        $display("[TB] phase: echo");
        clearLogs();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h11);
        waitCycles(1);
        checkOutput("d_rx_ready1", {31'd0, rx_data_ready}, 32'd1);
        rx_data = 8'h22;
        waitCycles(1);
        checkOutput("d_rx_ready2", {31'd0, rx_data_ready}, 32'd1);
        rx_data = 8'h33;
        waitCycles(1);
        checkOutput("d_rx_ready3", {31'd0, rx_data_ready}, 32'd1);
        rx_data_valid = 1'b0;
        waitTransfers(3, 30, "d");
        exp_q = '{8'h11, 8'h22, 8'h33};
        checkStream("d");

        // Tick arrives while echo byte 0x22 is waiting
        $display("[TB] phase: tick during echo");
        clearLogs();
        ch1 = int'($urandom_range(0, 65535));
        ch2 = int'($urandom_range(0, 65535));
        volt_ch1 = 16'(ch1);
        volt_ch2 = 16'(ch2);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h11);
        c0 = cyc;
        waitCycles(1);
        rx_data = 8'h22;
        waitCycles(1);
        rx_data = 8'h33;
        waitCycles(1);
        rx_data_valid = 1'b0;
        checkOutput("e_head_data", {24'd0, tx_data}, 32'h11);
        tx_data_ready = 1'b1;
        waitCycles(1);
        tx_data_ready = 1'b0;
        while (cyc < c0 + PERIOD + 5)
            waitCycles(1);
        checkOutput("e_waiting_valid", {31'd0, tx_data_valid}, 32'd1);
        checkOutput("e_waiting_data", {24'd0, tx_data}, 32'h22);
        tx_data_ready = 1'b1;
        waitTransfers(11, 100, "e");
        enable = 1'b0;
        exp_q = '{8'h11, 8'h22};
        expectFrame(3, ch1, ch2);
        exp_q.push_back(8'h33);
        checkStream("e");
        checkOutput("e_frame_seq", {24'd0, frame_seq}, 32'd4);

        // FIFO fill and overflow
        $display("[TB] phase: overflow");
        clearLogs();
        for (int i = 0; i < 5; i++)
            b[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, b[i]);
            waitCycles(1);
            checkOutput($sformatf("f_rx_ready_after_push%0d", i + 1),
                        {31'd0, rx_data_ready}, (i < 3) ? 32'd1 : 32'd0);
        end
        checkOutput("f_ovf_before", {31'd0, echo_ovf}, 32'd0);
        rx_data = b[4];
        waitCycles(1);
        rx_data_valid = 1'b0;
        checkOutput("f_ovf_after", {31'd0, echo_ovf}, 32'd1);
        tx_data_ready = 1'b1;
        waitTransfers(4, 40, "f");
        waitCycles(20);
        exp_q = '{b[0], b[1], b[2], b[3]};
        checkStream("f");
        checkOutput("f_rx_ready_end", {31'd0, rx_data_ready}, 32'd1);
        checkOutput("f_ovf_sticky", {31'd0, echo_ovf}, 32'd1);

        // Channel blocked across two ticks
        $display("[TB] phase: frame miss");
        clearLogs();
        e = 8'($urandom_range(0, 255));
        applyStimulus(1'b0, 1'b0, 1'b1, e);
        waitCycles(1);
        rx_data_valid = 1'b0;
        ch1 = int'($urandom_range(0, 65535));
        ch2 = int'($urandom_range(0, 65535));
        volt_ch1 = 16'(ch1);
        volt_ch2 = 16'(ch2);
        enable = 1'b1;
        c0 = cyc;
        while (cyc < c0 + PERIOD + 50)
            waitCycles(1);
        checkOutput("g_miss_after_one_tick", {31'd0, frame_miss}, 32'd0);
        while (cyc < c0 + 2 * PERIOD + 5)
            waitCycles(1);
        checkOutput("g_miss_after_two_ticks", {31'd0, frame_miss}, 32'd1);
        checkOutput("g_blocked_data", {24'd0, tx_data}, {24'd0, e});
        enable = 1'b0;
        tx_data_ready = 1'b1;
        waitTransfers(9, 60, "g");
        waitCycles(150);
        exp_q = '{e};
        expectFrame(4, ch1, ch2);
        checkStream("g");
        checkOutput("g_frame_seq", {24'd0, frame_seq}, 32'd5);

        // Telemetry disabled, echo still served
        $display("[TB] phase: disabled");
        clearLogs();
        e = 8'($urandom_range(0, 255));
        applyStimulus(1'b0, 1'b1, 1'b1, e);
        waitCycles(1);
        rx_data_valid = 1'b0;
        waitCycles(2 * PERIOD + 50);
        exp_q = '{e};
        checkStream("h");
        checkOutput("h_frame_seq", {24'd0, frame_seq}, 32'd5);

        // Reset in the middle of a frame
        $display("[TB] phase: reset mid-frame");
        clearLogs();
        volt_ch1 = 16'($urandom_range(0, 65535));
        volt_ch2 = 16'($urandom_range(0, 65535));
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        waitTransfers(3, 200, "i");
        #1 sys_rst_n = 1'b0;
        #1;
        checkOutput("i_rst_tx_valid", {31'd0, tx_data_valid}, 32'd0);
        checkOutput("i_rst_tx_data", {24'd0, tx_data}, 32'h0);
        checkOutput("i_rst_frame_seq", {24'd0, frame_seq}, 32'd0);
        checkOutput("i_rst_echo_ovf", {31'd0, echo_ovf}, 32'd0);
        checkOutput("i_rst_frame_miss", {31'd0, frame_miss}, 32'd0);
        enable = 1'b0;
        waitCycles(2);
        sys_rst_n = 1'b1;
        #1;
        checkOutput("i_rx_ready", {31'd0, rx_data_ready}, 32'd1);
        waitCycles(150);
        checkOutput("i_no_resume_len", got_q.size(), 32'd3);
        checkOutput("i_idle_valid", {31'd0, tx_data_valid}, 32'd0);
        checkOutput("i_idle_seq", {24'd0, frame_seq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
